// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
package bram_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o
);

  int k;

  // Walk from the farthest candidate back to rr_ptr so the closest match is written last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    k         = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (req_i[PTR_W'(k)]) begin
        gnt_o             = '0;
        gnt_o[PTR_W'(k)]  = 1'b1;
        gnt_idx_o         = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/bram_sp_read_first.sv
// Single-port READ_FIRST block RAM with registered output.
module bram_sp_read_first #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clka,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
    douta <= mem[addra];
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM among NUM_REQ valid/ready requesters, after
// filling the RAM with INIT_VALUE out of reset.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    NUM_REQ    = 2,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clka,
  input  logic                          rsta_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          init_done_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    init_done_q, init_done_d;
  logic [NUM_REQ-1:0]      rsp_vld_q, rsp_vld_d;

  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      gnt;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    xfer;
  logic                    wea;
  logic [ADDR_WIDTH-1:0]   addra;
  logic [DATA_WIDTH-1:0]   dina;

  // Requests are only seen once the registered init_done is up.
  assign arb_req = req_valid_i & {NUM_REQ{init_done_q}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i     (arb_req),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign xfer        = |gnt;
  assign req_ready_o = gnt;
  assign rsp_valid_o = rsp_vld_q;
  assign init_done_o = init_done_q;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_vld_d = '0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    case (state_q)
      ST_INIT: begin
        wea    = 1'b1;
        addra  = fill_q;
        dina   = INIT_VALUE;
        fill_d = fill_q + 1'b1;
        if (&fill_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          wea       = req_we_i[gnt_idx];
          addra     = req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          dina      = req_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          rsp_vld_d = gnt & ~req_we_i;
          rr_ptr_d  = PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
        end
      end
      default: state_d = ST_INIT;
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      fill_q      <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      rsp_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= init_done_d;
      rsp_vld_q   <= rsp_vld_d;
    end
  end

  bram_sp_read_first #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clka  (clka),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (rsp_rdata_o)
  );

endmodule
